// File: rtl/pulse_width_generate.sv
// Replays FIFO pulse widths as a registered high/low pulse train with a fixed low gap.
// Optional completed-pulse counter is built when PWG_PULSE_COUNT_EN is defined.
module pulse_width_generate #(
  parameter int DATA_WIDTH = 16,
  parameter int LOW_GAP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_from_pc,
  input  logic                  stop_from_pc,
  output logic                  rdreq_to_FIFO,
  input  logic                  rdempty_from_FIFO,
  input  logic [DATA_WIDTH-1:0] data_from_FIFO,
  output logic                  pulse_sig_out,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] pulse_count
);

  // state | meaning
  // IDLE  | output low, waiting for start with stop clear
  // FETCH | request next width from FIFO when it has data
  // LOAD  | FIFO word is valid; start the pulse or discard a zero width
  // HIGH  | output high, width_cnt counting down to zero
  // LOW   | output low, gap_cnt counting down to zero
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, HIGH, LOW} state_t;

  localparam logic [DATA_WIDTH-1:0] GAP_LOAD = DATA_WIDTH'(LOW_GAP - 1);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  state_t                state;
  logic                  start_q;
  logic                  stop_q;
  logic [DATA_WIDTH-1:0] width_cnt;
  logic [DATA_WIDTH-1:0] gap_cnt;
  logic                  pulse_done;

  // The FIFO samples the strobe at the FETCH->LOAD edge so its data is valid during LOAD.
  assign rdreq_to_FIFO = (state == FETCH) && start_q && !stop_q && !rdempty_from_FIFO;
  assign busy          = (state != IDLE);
  assign pulse_done    = (state == HIGH) && !stop_q && (width_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      pulse_sig_out <= 1'b0;
      width_cnt     <= '0;
      gap_cnt       <= '0;
    end else begin
      start_q <= start_from_pc;
      stop_q  <= stop_from_pc;
      case (state)
        IDLE: begin
          pulse_sig_out <= 1'b0;
          if (start_q && !stop_q) state <= FETCH;
        end
        FETCH: begin
          pulse_sig_out <= 1'b0;
          if (stop_q || !start_q) state <= IDLE;
          else if (!rdempty_from_FIFO) state <= LOAD;
        end
        LOAD: begin
          if (stop_q) begin
            pulse_sig_out <= 1'b0;
            state         <= IDLE;
          end else if (data_from_FIFO == '0) begin
            pulse_sig_out <= 1'b0;
            state         <= FETCH;
          end else begin
            width_cnt     <= data_from_FIFO - ONE;
            pulse_sig_out <= 1'b1;
            state         <= HIGH;
          end
        end
        HIGH: begin
          if (stop_q) begin
            pulse_sig_out <= 1'b0;
            state         <= IDLE;
          end else if (width_cnt != '0) begin
            width_cnt     <= width_cnt - ONE;
            pulse_sig_out <= 1'b1;
          end else begin
            pulse_sig_out <= 1'b0;
            gap_cnt       <= GAP_LOAD;
            state         <= LOW;
          end
        end
        LOW: begin
          pulse_sig_out <= 1'b0;
          if (stop_q) state <= IDLE;
          else if (gap_cnt != '0) gap_cnt <= gap_cnt - ONE;
          else state <= FETCH;
        end
        default: begin
          pulse_sig_out <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef PWG_PULSE_COUNT_EN
  logic [DATA_WIDTH-1:0] count_q;

  // Only pulses that reach their full width are counted; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else if (pulse_done) count_q <= count_q + ONE;
  end

  assign pulse_count = count_q;
`else
  logic unused_done;
  assign unused_done = pulse_done;
  assign pulse_count = '0;
`endif

endmodule

// File: tb/tb_pulse_width_generate.sv
// Directed bench for pulse_width_generate: FIFO model, pulse/gap width monitor, expected widths by hand.
module tb_pulse_width_generate;

  logic        clk;
  logic        reset;
  logic        start_from_pc;
  logic        stop_from_pc;
  logic        rdreq_to_FIFO;
  logic        rdempty_from_FIFO;
  logic [15:0] data_from_FIFO;
  logic        pulse_sig_out;
  logic        busy;
  logic [15:0] pulse_count;

  int checks;
  int failures;
  int exp_count;

`ifdef PWG_PULSE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  pulse_width_generate #(.DATA_WIDTH(16), .LOW_GAP(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .start_from_pc     (start_from_pc),
    .stop_from_pc      (stop_from_pc),
    .rdreq_to_FIFO     (rdreq_to_FIFO),
    .rdempty_from_FIFO (rdempty_from_FIFO),
    .data_from_FIFO    (data_from_FIFO),
    .pulse_sig_out     (pulse_sig_out),
    .busy              (busy),
    .pulse_count       (pulse_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normal (non-showahead) FIFO model.
  logic [15:0] fifo_mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int rdreq_cnt = 0;
  int rdreq_viol = 0;

  assign rdempty_from_FIFO = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rdreq_to_FIFO) begin
      data_from_FIFO <= fifo_mem[rd_ptr[5:0]];
      rd_ptr         <= rd_ptr + 1;
      rdreq_cnt      = rdreq_cnt + 1;
      if (rdempty_from_FIFO) rdreq_viol = rdreq_viol + 1;
    end
  end

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Pulse-width measurement side of the loopback: high widths and low gaps between pulses.
  int   widths[$];
  int   gaps[$];
  logic mon_prev = 1'b0;
  int   mon_run  = 0;
  bit   seen_fall = 1'b0;

  always @(negedge clk) begin
    if (pulse_sig_out === mon_prev) mon_run = mon_run + 1;
    else begin
      if (mon_prev) begin
        widths.push_back(mon_run);
        seen_fall = 1'b1;
      end else if (seen_fall) gaps.push_back(mon_run);
      mon_run = 1;
    end
    mon_prev = pulse_sig_out;
  end

  task automatic clear_meas();
    widths.delete();
    gaps.delete();
    seen_fall = 1'b0;
  endtask

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks = checks + 1;
    if (obs != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (pulse_sig_out !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, pulse_sig_out, lvl);
  endtask

  task automatic check_count(input string tag);
    check_val(tag, pulse_count, CNT_EN ? exp_count : 0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_count     = 0;
    reset         = 1'b0;
    start_from_pc = 1'b0;
    stop_from_pc  = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_pulse", pulse_sig_out, 0);
    check_val("rst_rdreq", rdreq_to_FIFO, 0);
    check_val("rst_busy", busy, 0);
    check_count("rst_count");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_busy", busy, 0);

    // Single pulse with latency checks.
    push(16'd5);
    clear_meas();
    start_from_pc = 1'b1;
    @(negedge clk);
    check_val("lat_rdreq_early", rdreq_to_FIFO, 0);
    @(negedge clk);
    check_val("lat_rdreq", rdreq_to_FIFO, 1);
    @(negedge clk);
    check_val("lat_pulse_early", pulse_sig_out, 0);
    @(negedge clk);
    check_val("lat_pulse", pulse_sig_out, 1);
    repeat (20) @(negedge clk);
    exp_count = 1;
    check_val("single_n", widths.size(), 1);
    if (widths.size() > 0) check_val("single_w", widths[0], 5);
    check_val("single_rdreq", rdreq_cnt, 1);
    check_count("single_count");
    check_val("single_fetch_busy", busy, 1);
    check_val("single_fetch_rdreq", rdreq_to_FIFO, 0);

    // Back-to-back pulses: gap = LOW_GAP + 2 = 6.
    clear_meas();
    push(16'd3);
    push(16'd1);
    push(16'd7);
    repeat (50) @(negedge clk);
    exp_count = 4;
    check_val("b2b_n", widths.size(), 3);
    if (widths.size() == 3) begin
      check_val("b2b_w0", widths[0], 3);
      check_val("b2b_w1", widths[1], 1);
      check_val("b2b_w2", widths[2], 7);
    end
    check_val("b2b_ngap", gaps.size(), 2);
    if (gaps.size() == 2) begin
      check_val("b2b_g0", gaps[0], 6);
      check_val("b2b_g1", gaps[1], 6);
    end
    check_count("b2b_count");

    // Start dropped while waiting in FETCH returns to IDLE.
    start_from_pc = 1'b0;
    repeat (3) @(negedge clk);
    check_val("start_drop_busy", busy, 0);

    // Zero width is discarded; full-scale width is not wrapped.
    clear_meas();
    push(16'd0);
    push(16'hFFFF);
    start_from_pc = 1'b1;
    wait_pulse(1'b1, 20, "max_rise");
    wait_pulse(1'b0, 70000, "max_fall");
    repeat (10) @(negedge clk);
    exp_count = 5;
    check_val("max_n", widths.size(), 1);
    if (widths.size() > 0) check_val("max_w", widths[0], 65535);
    check_count("max_count");
    check_val("max_fifo_empty", rdempty_from_FIFO, 1);

    // Stop at high cycle 40 of a 100-cycle pulse.
    clear_meas();
    push(16'd100);
    push(16'd9);
    push(16'd9);
    wait_pulse(1'b1, 20, "stop_rise");
    repeat (39) @(negedge clk);
    check_val("stop_still_high", pulse_sig_out, 1);
    stop_from_pc = 1'b1;
    repeat (2) @(negedge clk);
    check_val("stop_pulse", pulse_sig_out, 0);
    check_val("stop_busy", busy, 0);
    check_count("stop_count");
    check_val("stop_fifo_left", wr_ptr - rd_ptr, 2);
    stop_from_pc  = 1'b0;
    start_from_pc = 1'b0;
    repeat (3) @(negedge clk);
    check_val("stop_idle_busy", busy, 0);

    // Asynchronous reset in the middle of a pulse.
    start_from_pc = 1'b1;
    wait_pulse(1'b1, 20, "arst_rise");
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("arst_pulse", pulse_sig_out, 0);
    check_val("arst_busy", busy, 0);
    exp_count = 0;
    check_count("arst_count");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_meas();
    repeat (30) @(negedge clk);
    exp_count = 1;
    check_val("arst_replay_n", widths.size(), 1);
    if (widths.size() > 0) check_val("arst_replay_w", widths[0], 9);
    check_count("arst_replay_count");
    check_val("arst_fifo_empty", rdempty_from_FIFO, 1);

    // Loopback: measured widths must reproduce the programmed ones.
    clear_meas();
    push(16'd10);
    push(16'd20);
    push(16'd30);
    repeat (100) @(negedge clk);
    exp_count = 4;
    check_val("loop_n", widths.size(), 3);
    if (widths.size() == 3) begin
      check_val("loop_w0", widths[0], 10);
      check_val("loop_w1", widths[1], 20);
      check_val("loop_w2", widths[2], 30);
    end
    check_val("loop_ngap", gaps.size(), 2);
    if (gaps.size() == 2) begin
      check_val("loop_g0", gaps[0], 6);
      check_val("loop_g1", gaps[1], 6);
    end
    check_count("loop_count");
    check_val("total_rdreq", rdreq_cnt, 12);
    check_val("rdreq_while_empty", rdreq_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_width_generate.md
# pulse_width_generate

Replays a stream of pulse widths as a single-bit pulse train. Widths in clock cycles are popped from a FIFO, and each one becomes one high pulse of exactly that many cycles, followed by a fixed low gap. This is the transmit-side counterpart of the pulse-width measurement path. Its output can drive an analog test stimulus, or be looped back into the measurement chain for a self-test that must reproduce the same histogram.

## Interface
- DATA_WIDTH, 16, width of a pulse-width word, in cycles.
- LOW_GAP, 4, minimum low cycles between consecutive pulses; legal range 1..255.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_from_pc  in  1  level; enables generation.
- stop_from_pc  in  1  level; aborts generation and has priority over start.
- rdreq_to_FIFO  out  1  one-cycle FIFO read strobe.
- rdempty_from_FIFO  in  1  FIFO empty flag.
- data_from_FIFO  in  DATA_WIDTH  FIFO read data, valid the cycle after rdreq_to_FIFO (normal, non-showahead FIFO).
- pulse_sig_out  out  1  generated pulse train, registered.
- busy  out  1  high in every state except IDLE.
- pulse_count  out  DATA_WIDTH  number of completed pulses since reset (see Configuration).

## Operation
- start_from_pc and stop_from_pc are each registered once before use. The FSM acts on the registered copies.
- State IDLE:
  - pulse_sig_out = 0, rdreq_to_FIFO = 0.
  - Go to FETCH when registered start = 1 and registered stop = 0.
- State FETCH:
  - If stop = 1, go to IDLE.
  - Else if rdempty_from_FIFO = 0, assert rdreq_to_FIFO for one cycle and go to LOAD.
  - Else stay in FETCH with rdreq_to_FIFO = 0.
- State LOAD:
  - Capture data_from_FIFO as W.
  - If W = 0: no pulse is produced, the word is discarded, and the FSM returns to FETCH.
  - If W ≠ 0: load width_cnt = W−1, drive pulse_sig_out = 1, and go to HIGH.
  - A stop seen in LOAD discards the word and goes to IDLE.
- State HIGH:
  - pulse_sig_out = 1.
  - While width_cnt ≠ 0, decrement it.
  - When width_cnt = 0, drive pulse_sig_out = 0, load gap_cnt = LOW_GAP−1, increment pulse_count, and go to LOW.
- State LOW:
  - pulse_sig_out = 0.
  - While gap_cnt ≠ 0, decrement it.
  - When gap_cnt = 0, go to FETCH.
- Stop handling: registered stop = 1 in any non-IDLE state forces pulse_sig_out = 0 on the next edge and returns the FSM to IDLE.
  - A truncated pulse is not counted.
  - The FIFO is not flushed.
- Start deasserted alone, with stop = 0, does not abort. The pulse in progress and its LOW gap complete, and then the FSM returns to IDLE from FETCH.
- Counters are DATA_WIDTH bits wide. W = 2^DATA_WIDTH−1 is legal and gives exactly that many high cycles, with no wrap-around. pulse_count wraps modulo 2^DATA_WIDTH.
- rdreq_to_FIFO is never asserted while rdempty_from_FIFO = 1 or while in any state other than FETCH.

## Timing
- Reset values:
  - State = IDLE.
  - pulse_sig_out = 0, rdreq_to_FIFO = 0, busy = 0, pulse_count = 0.
  - width_cnt = 0, gap_cnt = 0.
  - Both start/stop sync registers = 0.
- Reset asserted mid-pulse clears everything immediately and asynchronously; pulse_sig_out drops without waiting for clk.
- Latency:
  - From start_from_pc rising to rdreq_to_FIFO: 2 cycles, given a non-empty FIFO (sync, then FETCH).
  - From rdreq_to_FIFO to pulse_sig_out rising: 2 cycles (LOAD registers the output).
- Pulse shape:
  - High for exactly W cycles.
  - The low interval between back-to-back pulses is LOW_GAP + 2 cycles (LOW_GAP + FETCH + LOAD).
- Stop: pulse_sig_out is low no later than 2 edges after stop_from_pc rises.

## Configuration
- PWG_PULSE_COUNT_EN:
  - Defined: the pulse_count register and incrementer are built and behave as described above.
  - Undefined: the counter logic is omitted and pulse_count is tied to 0. All other behaviour is identical.

## Test plan
- Single pulse: FIFO = {5}, LOW_GAP = 4, start = 1 → exactly one rdreq; pulse_sig_out high for 5 cycles; pulse_count = 1; the FSM then waits in FETCH.
- Back-to-back: FIFO = {3, 1, 7} → high widths 3, 1, 7; each low gap = 6 cycles; pulse_count = 3; no rdreq while empty.
- Zero and max width: FIFO = {0, 65535} → no pulse for the 0 word; one pulse of 65535 cycles; pulse_count = 1.
- Stop mid-pulse: W = 100, assert stop at high cycle 40 → output low within 2 edges; busy = 0; pulse_count unchanged; the remaining FIFO words are untouched.
- Async reset during HIGH: assert reset = 0 between edges → pulse_sig_out = 0 and busy = 0 with no clock edge; after release, start replays the remaining FIFO contents.
- Loopback: connect pulse_sig_out to the measurement block via FIFO {10, 20, 30} → measured widths read back as 10, 20, 30.
